picosoc_volume_ctrl: RTL and testbench
======================================

PICOSOC_VOLUME_CTRL -- requirements
Module: picosoc_volume_ctrl

Interface
REQ-001 SHALL have parameter NUM_VOLUMES, default 2, number of drive_volume_if channels, legal range 1..8.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1024, cycles allowed in ACK before forced completion; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports iomem_valid in 1, iomem_wstrb in 4, iomem_addr in 32, iomem_wdata in 32, iomem_rdata out 32, iomem_ready out 1, forming the PicoSoC iomem slave.
REQ-006 SHALL have port volumes  drive_volume_if.volume array [NUM_VOLUMES]: drives ready, mounted, readonly, size, ack; samples active, lba, blk_cnt, rd, wr.
REQ-007 SHALL have port irq  output  1  level interrupt = OR of (pending & irq_en).

Function
REQ-008 Access decode: write if |iomem_wstrb, else read; iomem_addr[11]=0 selects volume v = iomem_addr[8:6], register offset iomem_addr[5:2]; iomem_addr[11]=1 selects global registers.
REQ-009 iomem_ready SHALL pulse high exactly one cycle, the cycle after iomem_valid is first seen; it SHALL NOT reassert in the cycle following a ready pulse.
REQ-010 iomem_rdata SHALL be valid with iomem_ready and 0 otherwise; unmapped offsets and v >= NUM_VOLUMES read 0, writes ignored.
REQ-011 Per-volume RW regs: 0x00 READY[0], 0x04 MOUNTED[0], 0x08 READONLY[0], 0x0C SIZE[31:0]; each drives the same-named volume output directly.
REQ-012 Per-volume RO regs: 0x10 STATUS {27'b0, error, state[1:0], dir, active}; 0x14 LBA latched[31:0]; 0x18 BLK_CNT {26'b0, latched[5:0]}.
REQ-013 Per-volume WO reg 0x1C CMD[1:0]: 1=ACCEPT, 2=DONE, 3=ABORT, 0=no-op.
REQ-014 Global regs: 0x00 PENDING[NUM_VOLUMES-1:0] RO; 0x04 IRQ_EN[NUM_VOLUMES-1:0] RW; 0x08 ERROR[NUM_VOLUMES-1:0] RO; upper bits read 0.
REQ-015 Per volume, one FSM with states IDLE=0, PENDING=1, BUSY=2, ACK=3 (STATUS encoding).
REQ-016 IDLE: when rd or wr is high, latch lba, blk_cnt, dir (1=write, rd has priority if both high) in the same cycle.
REQ-017 IDLE request on a mounted volume, not (wr-only and readonly) -> PENDING, pending bit set next cycle.
REQ-018 IDLE request while unmounted, or write to readonly -> ACK directly, error set, pending not set.
REQ-019 PENDING + CMD ACCEPT -> BUSY, pending cleared; DONE in PENDING ignored.
REQ-020 BUSY + CMD DONE -> ACK; ACCEPT in BUSY ignored.
REQ-021 ACK: ack output high; -> IDLE the first cycle rd and wr are both low, ack low in IDLE.
REQ-022 ACK timeout: a 16-bit counter clears on ACK entry, increments each ACK cycle; at count == ACK_TIMEOUT-1 (ACK_TIMEOUT>0) -> IDLE with error set.
REQ-023 CMD ABORT from any state -> IDLE, pending and error cleared, ack low.
REQ-024 Error bit is cleared only by ABORT or reset; a new request is still accepted while error=1.
REQ-025 Latched LBA/BLK_CNT SHALL hold from capture until the next IDLE capture; later changes of volume lba/blk_cnt do not alter them.
REQ-026 CMD write and a same-cycle bus event: CMD has priority; a request in IDLE coincident with ABORT is taken the following cycle.
REQ-027 Volumes are independent; simultaneous requests on several volumes set several pending bits in one cycle.
REQ-028 irq SHALL be registered, updating the cycle after pending or IRQ_EN changes.

Reset
REQ-029 On reset high, immediately: all FSMs IDLE, pending=0, error=0, IRQ_EN=0, latches=0, READY=0, MOUNTED=0, READONLY=0, SIZE=0, ack=0, irq=0, iomem_ready=0, iomem_rdata=0.
REQ-030 Reset mid-transfer SHALL abandon the request without generating ack; after release a still-high rd/wr is captured as new.

Verification
REQ-031 Mount v0 (MOUNTED=1, SIZE=0x8000), rd=1 lba=0x1234 blk_cnt=4 -> PENDING bit0=1, STATUS=0x05 state PENDING, LBA reads 0x1234, BLK_CNT 4.
REQ-032 IRQ_EN=1, request on v0, ACCEPT, DONE, drop rd 3 cycles later -> irq high then low after ACCEPT; ack high exactly from DONE+1 until rd low, STATUS returns 0.
REQ-033 READONLY=1 on v1, wr=1 -> no pending, ERROR bit1=1, ack high until wr low; ABORT clears ERROR to 0.
REQ-034 ACK_TIMEOUT=8, rd held high after DONE -> ack high 8 cycles, then IDLE with error=1, then same rd recaptured as new PENDING.
REQ-035 NUM_VOLUMES=4, simultaneous rd on v0 and v3 -> PENDING reads 0x9; read at v=5 returns 0; every access sees one-cycle iomem_ready.
REQ-036 Assert reset while v0 in BUSY -> STATUS 0, ack never pulses, all outputs at REQ-029 values.

Source files
------------

// File: rtl/picosoc_volume_ctrl.sv
// PicoSoC iomem slave that arbitrates block requests from NUM_VOLUMES drive channels.
// Each channel runs a small IDLE/PENDING/BUSY/ACK handshake FSM that firmware steers
// through a per-volume CMD register; pending requests raise a maskable level irq.
module picosoc_volume_ctrl #(
  parameter int unsigned NUM_VOLUMES = 2,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  // PicoSoC iomem slave
  input  logic                        iomem_valid,
  input  logic [3:0]                  iomem_wstrb,
  input  logic [31:0]                 iomem_addr,
  input  logic [31:0]                 iomem_wdata,
  output logic [31:0]                 iomem_rdata,
  output logic                        iomem_ready,
  // drive_volume_if channels, flattened: channel v occupies slice v of each vector
  output logic [NUM_VOLUMES-1:0]      vol_ready_o,
  output logic [NUM_VOLUMES-1:0]      vol_mounted_o,
  output logic [NUM_VOLUMES-1:0]      vol_readonly_o,
  output logic [NUM_VOLUMES*32-1:0]   vol_size_o,
  output logic [NUM_VOLUMES-1:0]      vol_ack_o,
  input  logic [NUM_VOLUMES-1:0]      vol_active_i,
  input  logic [NUM_VOLUMES*32-1:0]   vol_lba_i,
  input  logic [NUM_VOLUMES*6-1:0]    vol_blk_cnt_i,
  input  logic [NUM_VOLUMES-1:0]      vol_rd_i,
  input  logic [NUM_VOLUMES-1:0]      vol_wr_i,
  output logic                        irq
);

  typedef enum logic [1:0] {StIdle = 2'd0, StPending = 2'd1, StBusy = 2'd2, StAck = 2'd3} state_e;

  localparam logic [1:0]  CmdAccept = 2'd1;
  localparam logic [1:0]  CmdDone   = 2'd2;
  localparam logic [1:0]  CmdAbort  = 2'd3;
  localparam logic [15:0] TmoLast   = 16'(ACK_TIMEOUT - 1);

  // Bus side state
  logic                             ready_q, ready_d;
  logic [31:0]                      rdata_q, rdata_d;
  logic [NUM_VOLUMES-1:0]           irq_en_q, irq_en_d;
  logic                             irq_q, irq_d;

  // Per-volume configuration registers
  logic [NUM_VOLUMES-1:0]           rdy_q, rdy_d;
  logic [NUM_VOLUMES-1:0]           mnt_q, mnt_d;
  logic [NUM_VOLUMES-1:0]           ro_q, ro_d;
  logic [NUM_VOLUMES-1:0][31:0]     size_q, size_d;

  // Per-volume request FSM state
  state_e                           state_q [NUM_VOLUMES];
  state_e                           state_d [NUM_VOLUMES];
  logic [NUM_VOLUMES-1:0]           pend_q, pend_d;
  logic [NUM_VOLUMES-1:0]           err_q, err_d;
  logic [NUM_VOLUMES-1:0]           dir_q, dir_d;
  logic [NUM_VOLUMES-1:0][31:0]     lba_q, lba_d;
  logic [NUM_VOLUMES-1:0][5:0]      blk_q, blk_d;
  logic [NUM_VOLUMES-1:0][15:0]     tmo_q, tmo_d;

  // Address decode
  logic                             access;
  logic                             is_wr;
  logic                             is_glb;
  logic [2:0]                       vsel;
  logic [3:0]                       off;
  logic [NUM_VOLUMES-1:0]           wr_hit;
  logic [31:0]                      rd_val;
  logic                             unused_addr;

  // An access is taken only on the first cycle valid is seen; the ready cycle blocks a repeat.
  assign access      = iomem_valid & ~ready_q;
  assign is_wr       = |iomem_wstrb;
  assign is_glb      = iomem_addr[11];
  assign vsel        = iomem_addr[8:6];
  assign off         = iomem_addr[5:2];
  assign unused_addr = ^{iomem_addr[31:12], iomem_addr[10:9], iomem_addr[1:0]};

  assign iomem_ready    = ready_q;
  assign iomem_rdata    = rdata_q;
  assign irq            = irq_q;
  assign vol_ready_o    = rdy_q;
  assign vol_mounted_o  = mnt_q;
  assign vol_readonly_o = ro_q;
  assign vol_size_o     = size_q;

  // Write strobes per volume and ack outputs
  always_comb begin
    wr_hit    = '0;
    vol_ack_o = '0;
    for (int v = 0; v < NUM_VOLUMES; v++) begin
      wr_hit[v]    = access & is_wr & ~is_glb & (vsel == 3'(v));
      vol_ack_o[v] = (state_q[v] == StAck);
    end
  end

  // Read mux; out-of-range volumes and unmapped offsets fall through to 0
  always_comb begin
    rd_val = '0;
    if (is_glb) begin
      case (off)
        4'h0:    rd_val[NUM_VOLUMES-1:0] = pend_q;
        4'h1:    rd_val[NUM_VOLUMES-1:0] = irq_en_q;
        4'h2:    rd_val[NUM_VOLUMES-1:0] = err_q;
        default: rd_val = '0;
      endcase
    end else begin
      for (int v = 0; v < NUM_VOLUMES; v++) begin
        if (vsel == 3'(v)) begin
          case (off)
            4'h0:    rd_val = {31'b0, rdy_q[v]};
            4'h1:    rd_val = {31'b0, mnt_q[v]};
            4'h2:    rd_val = {31'b0, ro_q[v]};
            4'h3:    rd_val = size_q[v];
            4'h4:    rd_val = {27'b0, err_q[v], state_q[v], dir_q[v], vol_active_i[v]};
            4'h5:    rd_val = lba_q[v];
            4'h6:    rd_val = {26'b0, blk_q[v]};
            default: rd_val = '0;
          endcase
        end
      end
    end
  end

  // Bus handshake and configuration register next-state
  always_comb begin
    ready_d  = access;
    rdata_d  = (access && !is_wr) ? rd_val : 32'h0;
    irq_en_d = irq_en_q;
    irq_d    = |(pend_q & irq_en_q);
    rdy_d    = rdy_q;
    mnt_d    = mnt_q;
    ro_d     = ro_q;
    size_d   = size_q;
    if (access && is_wr && is_glb && off == 4'h1) begin
      irq_en_d = iomem_wdata[NUM_VOLUMES-1:0];
    end
    for (int v = 0; v < NUM_VOLUMES; v++) begin
      if (wr_hit[v]) begin
        case (off)
          4'h0:    rdy_d[v]  = iomem_wdata[0];
          4'h1:    mnt_d[v]  = iomem_wdata[0];
          4'h2:    ro_d[v]   = iomem_wdata[0];
          4'h3:    size_d[v] = iomem_wdata;
          default: ;
        endcase
      end
    end
  end

  // Per-volume request FSM next-state; CMD writes override any same-cycle bus event
  always_comb begin
    logic       req;
    logic       wr_only;
    logic [1:0] cmd;
    req     = 1'b0;
    wr_only = 1'b0;
    cmd     = 2'd0;
    pend_d  = pend_q;
    err_d   = err_q;
    dir_d   = dir_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    tmo_d   = tmo_q;
    for (int v = 0; v < NUM_VOLUMES; v++) begin
      state_d[v] = state_q[v];
      req        = vol_rd_i[v] | vol_wr_i[v];
      wr_only    = vol_wr_i[v] & ~vol_rd_i[v];
      cmd        = (wr_hit[v] && off == 4'h7) ? iomem_wdata[1:0] : 2'd0;
      if (cmd == CmdAbort) begin
        state_d[v] = StIdle;
        pend_d[v]  = 1'b0;
        err_d[v]   = 1'b0;
      end else begin
        unique case (state_q[v])
          StIdle: begin
            if (req) begin
              lba_d[v] = vol_lba_i[v*32 +: 32];
              blk_d[v] = vol_blk_cnt_i[v*6 +: 6];
              dir_d[v] = wr_only;
              if (mnt_q[v] && !(wr_only && ro_q[v])) begin
                state_d[v] = StPending;
                pend_d[v]  = 1'b1;
              end else begin
                state_d[v] = StAck;
                err_d[v]   = 1'b1;
                tmo_d[v]   = '0;
              end
            end
          end
          StPending: begin
            if (cmd == CmdAccept) begin
              state_d[v] = StBusy;
              pend_d[v]  = 1'b0;
            end
          end
          StBusy: begin
            if (cmd == CmdDone) begin
              state_d[v] = StAck;
              tmo_d[v]   = '0;
            end
          end
          StAck: begin
            if (!req) begin
              state_d[v] = StIdle;
            end else if (ACK_TIMEOUT != 0 && tmo_q[v] == TmoLast) begin
              // Host never released the request: force completion and flag it.
              state_d[v] = StIdle;
              err_d[v]   = 1'b1;
            end else begin
              tmo_d[v] = tmo_q[v] + 16'd1;
            end
          end
          default: state_d[v] = StIdle;
        endcase
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      rdy_q    <= '0;
      mnt_q    <= '0;
      ro_q     <= '0;
      size_q   <= '0;
      pend_q   <= '0;
      err_q    <= '0;
      dir_q    <= '0;
      lba_q    <= '0;
      blk_q    <= '0;
      tmo_q    <= '0;
      for (int v = 0; v < NUM_VOLUMES; v++) begin
        state_q[v] <= StIdle;
      end
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdy_q    <= rdy_d;
      mnt_q    <= mnt_d;
      ro_q     <= ro_d;
      size_q   <= size_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
      lba_q    <= lba_d;
      blk_q    <= blk_d;
      tmo_q    <= tmo_d;
      for (int v = 0; v < NUM_VOLUMES; v++) begin
        state_q[v] <= state_d[v];
      end
    end
  end

endmodule

// File: tb/tb_picosoc_volume_ctrl.sv
// Directed bench for picosoc_volume_ctrl: four volumes, short ack timeout.
module tb_picosoc_volume_ctrl;

  localparam int NV = 4;
  localparam logic [31:0] G = 32'h800;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            iomem_valid = 1'b0;
  logic [3:0]      iomem_wstrb = 4'h0;
  logic [31:0]     iomem_addr = '0;
  logic [31:0]     iomem_wdata = '0;
  logic [31:0]     iomem_rdata;
  logic            iomem_ready;
  logic [NV-1:0]   vol_ready, vol_mounted, vol_readonly, vol_ack;
  logic [NV*32-1:0] vol_size;
  logic [NV-1:0]   vol_active = '0;
  logic [NV*32-1:0] vol_lba = '0;
  logic [NV*6-1:0] vol_blk = '0;
  logic [NV-1:0]   vol_rd = '0;
  logic [NV-1:0]   vol_wr = '0;
  logic            irq;

  int total = 0;
  int bad = 0;
  int ack0_hi = 0;
  int ack2_hi = 0;

  picosoc_volume_ctrl #(.NUM_VOLUMES(NV), .ACK_TIMEOUT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .iomem_valid    (iomem_valid),
    .iomem_wstrb    (iomem_wstrb),
    .iomem_addr     (iomem_addr),
    .iomem_wdata    (iomem_wdata),
    .iomem_rdata    (iomem_rdata),
    .iomem_ready    (iomem_ready),
    .vol_ready_o    (vol_ready),
    .vol_mounted_o  (vol_mounted),
    .vol_readonly_o (vol_readonly),
    .vol_size_o     (vol_size),
    .vol_ack_o      (vol_ack),
    .vol_active_i   (vol_active),
    .vol_lba_i      (vol_lba),
    .vol_blk_cnt_i  (vol_blk),
    .vol_rd_i       (vol_rd),
    .vol_wr_i       (vol_wr),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Count cycles each watched ack line is high
  always @(negedge clk) begin
    if (vol_ack[0] === 1'b1) ack0_hi++;
    if (vol_ack[2] === 1'b1) ack2_hi++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [31:0] va(input int v, input int offs);
    return 32'(v * 64 + offs);
  endfunction

  // One PicoRV32-style access: valid held until the edge after ready is seen
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] q);
    int n;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_wstrb = w ? 4'hf : 4'h0;
    iomem_addr  = a;
    iomem_wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (iomem_ready !== 1'b1 && n < 4);
    total++;
    if (n != 1 || iomem_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_latency addr=%h: got %0d cycles want 1", a, n);
    end
    q = iomem_rdata;
    @(posedge clk); #1;
    total++;
    if (iomem_ready !== 1'b0 || iomem_rdata !== 32'h0) begin
      bad++;
      $display("FAIL ready_drop addr=%h: got ready=%b rdata=%h want ready=0 rdata=0",
               a, iomem_ready, iomem_rdata);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b1, a, d, q);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] q);
    bus(1'b0, a, 32'h0, q);
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({iomem_ready, iomem_rdata, irq, vol_ack, vol_ready, vol_mounted, vol_readonly} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b rdata=%h irq=%b ack=%b rdy=%b mnt=%b ro=%b want 0",
               iomem_ready, iomem_rdata, irq, vol_ack, vol_ready, vol_mounted, vol_readonly);
    end
    total++;
    if (vol_size !== '0) begin
      bad++;
      $display("FAIL reset_size: got %h want 0", vol_size);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read_capture;
    logic [31:0] q;
    vol_active[0] = 1'b1;
    bus_wr(va(0, 'h04), 32'h1);
    bus_wr(va(0, 'h0C), 32'h8000);
    bus_wr(va(0, 'h00), 32'h1);
    total++;
    if (vol_mounted[0] !== 1'b1 || vol_ready[0] !== 1'b1 || vol_size[31:0] !== 32'h8000) begin
      bad++;
      $display("FAIL cfg_outputs: got mnt=%b rdy=%b size=%h want 1 1 00008000",
               vol_mounted[0], vol_ready[0], vol_size[31:0]);
    end
    bus_rd(va(0, 'h0C), q);
    total++;
    if (q !== 32'h8000) begin bad++; $display("FAIL size_read: got %h want 00008000", q); end
    @(negedge clk);
    vol_lba[31:0] = 32'h1234;
    vol_blk[5:0]  = 6'd4;
    vol_rd[0]     = 1'b1;
    @(posedge clk); #1;
    vol_lba[31:0] = 32'hdead_beef;
    vol_blk[5:0]  = 6'd7;
    bus_wr(va(0, 'h1C), 32'h2);  // DONE while pending must be ignored
    bus_rd(va(0, 'h10), q);
    total++;
    if (q !== 32'h05) begin bad++; $display("FAIL status_pending: got %h want 00000005", q); end
    bus_rd(G, q);
    total++;
    if (q !== 32'h1) begin bad++; $display("FAIL pending_v0: got %h want 00000001", q); end
    bus_rd(va(0, 'h14), q);
    total++;
    if (q !== 32'h1234) begin bad++; $display("FAIL lba_latch: got %h want 00001234", q); end
    bus_rd(va(0, 'h18), q);
    total++;
    if (q !== 32'h4) begin bad++; $display("FAIL blk_latch: got %h want 00000004", q); end
  endtask

  task automatic test_irq_flow;
    logic [31:0] q;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_masked: got %b want 0", irq); end
    bus_wr(G + 32'h4, 32'h1);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_raise: got %b want 1", irq); end
    bus_wr(va(0, 'h1C), 32'h1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_wr(va(0, 'h1C), 32'h1);  // second ACCEPT in BUSY is a no-op
    bus_rd(va(0, 'h10), q);
    total++;
    if (q !== 32'h09) begin bad++; $display("FAIL status_busy: got %h want 00000009", q); end
    bus_wr(va(0, 'h1C), 32'h2);
    total++;
    if (vol_ack[0] !== 1'b1) begin bad++; $display("FAIL ack_after_done: got %b want 1", vol_ack[0]); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (vol_ack[0] !== 1'b1) begin bad++; $display("FAIL ack_hold%0d: got %b want 1", i, vol_ack[0]); end
    end
    @(negedge clk);
    vol_rd[0]     = 1'b0;
    vol_active[0] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (vol_ack[0] !== 1'b0) begin bad++; $display("FAIL ack_release: got %b want 0", vol_ack[0]); end
    bus_rd(va(0, 'h10), q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL status_idle: got %h want 00000000", q); end
  endtask

  task automatic test_readonly;
    logic [31:0] q;
    bus_wr(va(1, 'h04), 32'h1);
    bus_wr(va(1, 'h08), 32'h1);
    @(negedge clk);
    vol_lba[63:32] = 32'h55;
    vol_wr[1]      = 1'b1;
    @(posedge clk); #1;
    total++;
    if (vol_ack[1] !== 1'b1) begin bad++; $display("FAIL ro_ack: got %b want 1", vol_ack[1]); end
    bus_rd(G + 32'h8, q);
    total++;
    if (q !== 32'h2) begin bad++; $display("FAIL ro_error: got %h want 00000002", q); end
    total++;
    if (vol_ack[1] !== 1'b1) begin bad++; $display("FAIL ro_ack_hold: got %b want 1", vol_ack[1]); end
    @(negedge clk);
    vol_wr[1] = 1'b0;
    @(posedge clk); #1;
    total++;
    if (vol_ack[1] !== 1'b0) begin bad++; $display("FAIL ro_ack_drop: got %b want 0", vol_ack[1]); end
    bus_rd(G, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL ro_no_pending: got %h want 00000000", q); end
    bus_rd(va(1, 'h10), q);
    total++;
    if (q !== 32'h12) begin bad++; $display("FAIL ro_status: got %h want 00000012", q); end
    bus_wr(va(1, 'h1C), 32'h3);
    bus_rd(G + 32'h8, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL abort_error: got %h want 00000000", q); end
  endtask

  task automatic test_timeout;
    logic [31:0] q;
    int n;
    int base;
    bus_wr(va(2, 'h04), 32'h1);
    @(negedge clk);
    vol_rd[2] = 1'b1;
    bus_wr(va(2, 'h1C), 32'h1);
    base = ack2_hi;
    bus_wr(va(2, 'h1C), 32'h2);
    n = 0;
    while (vol_ack[2] === 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (vol_ack[2] !== 1'b0) begin bad++; $display("FAIL tmo_expire: got ack=%b want 0", vol_ack[2]); end
    bus_rd(G + 32'h8, q);
    total++;
    if (q !== 32'h4) begin bad++; $display("FAIL tmo_error: got %h want 00000004", q); end
    total++;
    if (ack2_hi - base != 8) begin bad++; $display("FAIL tmo_ack_len: got %0d want 8", ack2_hi - base); end
    bus_rd(va(2, 'h10), q);
    total++;
    if (q !== 32'h14) begin bad++; $display("FAIL tmo_recapture: got %h want 00000014", q); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_mask_v2: got %b want 0", irq); end
    @(negedge clk);
    vol_rd[2] = 1'b0;
    bus_wr(va(2, 'h1C), 32'h3);
    bus_rd(va(2, 'h10), q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL tmo_abort: got %h want 00000000", q); end
  endtask

  task automatic test_multi;
    logic [31:0] q;
    bus_wr(va(3, 'h04), 32'h1);
    @(negedge clk);
    vol_active[0] = 1'b1;
    vol_rd[0] = 1'b1;
    vol_rd[3] = 1'b1;
    @(posedge clk); #1;
    bus_rd(G, q);
    total++;
    if (q !== 32'h9) begin bad++; $display("FAIL multi_pending: got %h want 00000009", q); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL multi_irq: got %b want 1", irq); end
    bus_wr(va(5, 'h0C), 32'hffff_ffff);
    bus_rd(va(5, 'h0C), q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL oob_volume: got %h want 00000000", q); end
    bus_rd(G + 32'hC, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL glb_unmapped: got %h want 00000000", q); end
  endtask

  task automatic test_reset_busy;
    logic [31:0] q;
    int base;
    bus_wr(va(0, 'h1C), 32'h1);
    bus_rd(va(0, 'h10), q);
    total++;
    if (q !== 32'h09) begin bad++; $display("FAIL busy_before_reset: got %h want 00000009", q); end
    base = ack0_hi;
    @(negedge clk);
    reset      = 1'b1;
    vol_rd     = '0;
    vol_active = '0;
    #1;
    total++;
    if ({iomem_ready, iomem_rdata, irq, vol_ack, vol_ready, vol_mounted, vol_readonly} !== '0
        || vol_size !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got ack=%b irq=%b mnt=%b rdy=%b size=%h want 0",
               vol_ack, irq, vol_mounted, vol_ready, vol_size);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    bus_rd(va(0, 'h10), q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL status_after_reset: got %h want 00000000", q); end
    bus_rd(G, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("FAIL pending_after_reset: got %h want 00000000", q); end
    total++;
    if (ack0_hi != base) begin bad++; $display("FAIL ack_during_reset: got %0d want 0", ack0_hi - base); end
  endtask

  initial begin
    test_reset();
    test_read_capture();
    test_irq_flow();
    test_readonly();
    test_timeout();
    test_multi();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
